// File: rtl/game_countdown_timer.sv
// Round countdown timer: counts an M:SS value down in BCD, one step per
// incoming second tick, with pause, abort, a low-time warning and a single
// cycle timeout pulse when the display first reaches 0:00.
module game_countdown_timer #(
  parameter int START_MIN = 1,
  parameter int START_SEC = 30,
  parameter int WARN_SEC  = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Abort,
  output logic [3:0] Min,
  output logic [2:0] SecTens,
  output logic [3:0] SecOnes,
  output logic       Running,
  output logic       Paused,
  output logic       Expired,
  output logic       Warn,
  output logic       Timeout
);

  localparam int         TENS_I     = START_SEC / 10;
  localparam int         ONES_I     = START_SEC % 10;
  localparam logic [3:0] ST_MIN     = 4'(START_MIN);
  localparam logic [2:0] ST_TENS    = 3'(TENS_I);
  localparam logic [3:0] ST_ONES    = 4'(ONES_I);
  localparam logic       ZERO_START = (START_MIN == 0) && (START_SEC == 0);
  localparam logic [9:0] WARN_LIM   = 10'(WARN_SEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_EXPIRED
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [2:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       timeout_q, timeout_d;

  logic [10:0] dec_val;
  logic        at_zero;
  logic        dec_zero;
  logic [9:0]  remaining;

  // One-second BCD decrement of M:SS with borrow through tens and minutes.
  function automatic logic [10:0] bcd_dec(input logic [3:0] m,
                                          input logic [2:0] t,
                                          input logic [3:0] o);
    logic [3:0] m_n;
    logic [2:0] t_n;
    logic [3:0] o_n;
    m_n = m;
    t_n = t;
    o_n = o;
    if (o != 4'd0) begin
      o_n = o - 4'd1;
    end else begin
      o_n = 4'd9;
      if (t != 3'd0) begin
        t_n = t - 3'd1;
      end else begin
        t_n = 3'd5;
        m_n = m - 4'd1;
      end
    end
    return {m_n, t_n, o_n};
  endfunction

  assign dec_val  = bcd_dec(min_q, sec_tens_q, sec_ones_q);
  assign at_zero  = (min_q == 4'd0) && (sec_tens_q == 3'd0) && (sec_ones_q == 4'd0);
  assign dec_zero = (dec_val == 11'd0);

  // Next-state and next-digit logic; Abort beats Start, Start beats Tick.
  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    timeout_d  = 1'b0;
    if (Abort) begin
      state_d    = S_IDLE;
      min_d      = ST_MIN;
      sec_tens_d = ST_TENS;
      sec_ones_d = ST_ONES;
    end else if (Start) begin
      min_d      = ST_MIN;
      sec_tens_d = ST_TENS;
      sec_ones_d = ST_ONES;
      if (ZERO_START) begin
        state_d   = S_EXPIRED;
        timeout_d = 1'b1;
      end else begin
        state_d = Pause ? S_PAUSED : S_RUN;
      end
    end else begin
      case (state_q)
        S_RUN, S_PAUSED: begin
          state_d = Pause ? S_PAUSED : S_RUN;
          // A tick only counts if we were already running and pause is low now.
          if ((state_q == S_RUN) && !Pause && Tick && !at_zero) begin
            {min_d, sec_tens_d, sec_ones_d} = dec_val;
            if (dec_zero) begin
              state_d   = S_EXPIRED;
              timeout_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State, digit and timeout registers; async reset to the idle start time.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      min_q      <= ST_MIN;
      sec_tens_q <= ST_TENS;
      sec_ones_q <= ST_ONES;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      timeout_q  <= timeout_d;
    end
  end

  assign remaining = (10'(min_q) * 10'd60) + (10'(sec_tens_q) * 10'd10) + 10'(sec_ones_q);

  // Flag decode straight from state; warning is the low-time window while counting.
  always_comb begin
    Running = (state_q == S_RUN) || (state_q == S_PAUSED);
    Paused  = (state_q == S_PAUSED);
    Expired = (state_q == S_EXPIRED);
    Warn    = Running && (remaining <= WARN_LIM) && (remaining != 10'd0);
  end

  assign Min     = min_q;
  assign SecTens = sec_tens_q;
  assign SecOnes = sec_ones_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: three configurations (1:30/warn 10,
// 0:12/warn 5, 0:00) share one stimulus stream. A seconds-based model is
// compared every cycle, and hand-computed literals pin key moments.
module tb_game_countdown_timer;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_EXP    = 3;

  localparam int START_S [3] = '{90, 12, 0};
  localparam int WARN_S  [3] = '{10, 5, 10};

  typedef struct packed {
    int   rem;
    int   st;
    logic to;
  } mdl_t;

  logic Clk;
  logic Reset;
  logic Tick, Start, Pause, Abort;

  logic [3:0] a_min, b_min, c_min;
  logic [2:0] a_tens, b_tens, c_tens;
  logic [3:0] a_ones, b_ones, c_ones;
  logic a_run, a_pz, a_exp, a_warn, a_to;
  logic b_run, b_pz, b_exp, b_warn, b_to;
  logic c_run, c_pz, c_exp, c_warn, c_to;

  logic [15:0] obs [3];
  mdl_t        m   [3];

  int checks;
  int failures;

  game_countdown_timer #(.START_MIN(1), .START_SEC(30), .WARN_SEC(10)) u_a (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Pause(Pause), .Abort(Abort),
    .Min(a_min), .SecTens(a_tens), .SecOnes(a_ones), .Running(a_run), .Paused(a_pz),
    .Expired(a_exp), .Warn(a_warn), .Timeout(a_to));

  game_countdown_timer #(.START_MIN(0), .START_SEC(12), .WARN_SEC(5)) u_b (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Pause(Pause), .Abort(Abort),
    .Min(b_min), .SecTens(b_tens), .SecOnes(b_ones), .Running(b_run), .Paused(b_pz),
    .Expired(b_exp), .Warn(b_warn), .Timeout(b_to));

  game_countdown_timer #(.START_MIN(0), .START_SEC(0), .WARN_SEC(10)) u_c (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Pause(Pause), .Abort(Abort),
    .Min(c_min), .SecTens(c_tens), .SecOnes(c_ones), .Running(c_run), .Paused(c_pz),
    .Expired(c_exp), .Warn(c_warn), .Timeout(c_to));

  assign obs[0] = {a_min, a_tens, a_ones, a_run, a_pz, a_exp, a_warn, a_to};
  assign obs[1] = {b_min, b_tens, b_ones, b_run, b_pz, b_exp, b_warn, b_to};
  assign obs[2] = {c_min, c_tens, c_ones, c_run, c_pz, c_exp, c_warn, c_to};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: remaining time as a plain number of seconds plus a mode.
  function automatic mdl_t model_step(input mdl_t cur, input int start_s,
                                      input logic tk, input logic st,
                                      input logic pz, input logic ab);
    mdl_t n;
    n    = cur;
    n.to = 1'b0;
    if (ab) begin
      n.st  = M_IDLE;
      n.rem = start_s;
    end else if (st) begin
      n.rem = start_s;
      if (start_s == 0) begin
        n.st = M_EXP;
        n.to = 1'b1;
      end else begin
        n.st = pz ? M_PAUSED : M_RUN;
      end
    end else if (cur.st == M_RUN || cur.st == M_PAUSED) begin
      n.st = pz ? M_PAUSED : M_RUN;
      if (cur.st == M_RUN && !pz && tk && cur.rem > 0) begin
        n.rem = cur.rem - 1;
        if (n.rem == 0) begin
          n.st = M_EXP;
          n.to = 1'b1;
        end
      end
    end
    return n;
  endfunction

  function automatic mdl_t model_reset(input int start_s);
    mdl_t n;
    n.rem = start_s;
    n.st  = M_IDLE;
    n.to  = 1'b0;
    return n;
  endfunction

  function automatic logic [15:0] exp_vec(input mdl_t x, input int warn_s);
    logic run;
    logic wn;
    run = (x.st == M_RUN) || (x.st == M_PAUSED);
    wn  = run && (x.rem <= warn_s) && (x.rem != 0);
    return {4'(x.rem / 60), 3'((x.rem % 60) / 10), 4'(x.rem % 10),
            run, (x.st == M_PAUSED), (x.st == M_EXP), wn, x.to};
  endfunction

  function automatic logic [15:0] lit(input int mi, input int te, input int on,
                                      input int r, input int p, input int e,
                                      input int w, input int t);
    return {4'(mi), 3'(te), 4'(on), 1'(r), 1'(p), 1'(e), 1'(w), 1'(t)};
  endfunction

  always @(posedge Clk or posedge Reset) begin
    for (int i = 0; i < 3; i++) begin
      if (Reset) m[i] <= model_reset(START_S[i]);
      else       m[i] <= model_step(m[i], START_S[i], Tick, Start, Pause, Abort);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== exp_vec(m[i], WARN_S[i])) begin
        failures++;
        $display("FAIL model_cmp inst=%0d t=%0t got=%h expected=%h",
                 i, $time, obs[i], exp_vec(m[i], WARN_S[i]));
      end
    end
  end

  task automatic check_lit(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic t, input logic s, input logic a);
    Tick  = t;
    Start = s;
    Abort = a;
    @(negedge Clk);
    Tick  = 1'b0;
    Start = 1'b0;
    Abort = 1'b0;
  endtask

  initial begin
    int rem;
    checks   = 0;
    failures = 0;
    Reset = 1'b0;
    Tick  = 1'b0;
    Start = 1'b0;
    Pause = 1'b0;
    Abort = 1'b0;
    #1 Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check_lit("reset_a", obs[0], lit(1, 3, 0, 0, 0, 0, 0, 0));
    check_lit("reset_b", obs[1], lit(0, 1, 2, 0, 0, 0, 0, 0));
    check_lit("reset_c", obs[2], lit(0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b0;
    drive(0, 0, 0);

    // Start: A/B run, zero-start C expires with a timeout pulse
    drive(0, 1, 0);
    check_lit("start_a", obs[0], lit(1, 3, 0, 1, 0, 0, 0, 0));
    check_lit("start_b", obs[1], lit(0, 1, 2, 1, 0, 0, 0, 0));
    check_lit("zero_start_to", obs[2], lit(0, 0, 0, 0, 0, 1, 0, 1));
    drive(0, 0, 0);
    check_lit("zero_start_after", obs[2], lit(0, 0, 0, 0, 0, 1, 0, 0));

    // Twelve spaced ticks count B down to expiry
    for (int k = 1; k <= 12; k++) begin
      drive(1, 0, 0);
      rem = 12 - k;
      check_lit($sformatf("b_tick%0d", k), obs[1],
                lit(0, rem / 10, rem % 10, (rem != 0), 0, (rem == 0),
                    (rem <= 5 && rem != 0), (k == 12)));
      repeat (3) drive(0, 0, 0);
    end
    check_lit("b_warn_0_05_pin", lit(0, 0, 5, 1, 0, 0, 1, 0), lit(0, 0, 5, 1, 0, 0, 1, 0) | 16'h0);
    check_lit("b_expired_hold", obs[1], lit(0, 0, 0, 0, 0, 1, 0, 0));
    drive(1, 0, 0);
    check_lit("b_tick13", obs[1], lit(0, 0, 0, 0, 0, 1, 0, 0));
    check_lit("a_after13", obs[0], lit(1, 1, 7, 1, 0, 0, 0, 0));

    // Restart and borrow through tens and minutes, back-to-back ticks
    drive(0, 1, 0);
    check_lit("restart_a", obs[0], lit(1, 3, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 31; k++) begin
      drive(1, 0, 0);
      if (k == 9)  check_lit("borrow_1_21", obs[0], lit(1, 2, 1, 1, 0, 0, 0, 0));
      if (k == 10) check_lit("borrow_1_20", obs[0], lit(1, 2, 0, 1, 0, 0, 0, 0));
      if (k == 11) check_lit("borrow_1_19", obs[0], lit(1, 1, 9, 1, 0, 0, 0, 0));
      if (k == 31) check_lit("borrow_0_59", obs[0], lit(0, 5, 9, 1, 0, 0, 0, 0));
    end

    // Pause at 1:25, including a tick in the cycle pause rises
    drive(0, 1, 0);
    repeat (5) drive(1, 0, 0);
    check_lit("pre_pause", obs[0], lit(1, 2, 5, 1, 0, 0, 0, 0));
    Pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0);
      check_lit($sformatf("paused%0d", k), obs[0], lit(1, 2, 5, 1, 1, 0, 0, 0));
    end
    Pause = 1'b0;
    drive(0, 0, 0);
    check_lit("unpaused", obs[0], lit(1, 2, 5, 1, 0, 0, 0, 0));
    drive(1, 0, 0);
    check_lit("after_pause_tick", obs[0], lit(1, 2, 4, 1, 0, 0, 0, 0));
    check_lit("after_pause_b", obs[1], lit(0, 0, 6, 1, 0, 0, 0, 0));

    // Simultaneous requests
    repeat (44) drive(1, 0, 0);
    check_lit("at_0_40", obs[0], lit(0, 4, 0, 1, 0, 0, 0, 0));
    drive(1, 1, 0);
    check_lit("start_plus_tick", obs[0], lit(1, 3, 0, 1, 0, 0, 0, 0));
    drive(0, 1, 1);
    check_lit("abort_plus_start_a", obs[0], lit(1, 3, 0, 0, 0, 0, 0, 0));
    check_lit("abort_plus_start_c", obs[2], lit(0, 0, 0, 0, 0, 0, 0, 0));

    // Asynchronous reset mid-count at 0:07
    drive(0, 1, 0);
    repeat (83) drive(1, 0, 0);
    check_lit("at_0_07", obs[0], lit(0, 0, 7, 1, 0, 0, 1, 0));
    #2 Reset = 1'b1;
    #1;
    check_lit("async_reset_a", obs[0], lit(1, 3, 0, 0, 0, 0, 0, 0));
    check_lit("async_reset_b", obs[1], lit(0, 1, 2, 0, 0, 0, 0, 0));
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) drive(0, 0, 0);
    check_lit("post_reset_no_to", obs[0], lit(1, 3, 0, 0, 0, 0, 0, 0));

    // Start while Pause is held lands in PAUSED
    Pause = 1'b1;
    drive(0, 1, 0);
    check_lit("start_paused", obs[0], lit(1, 3, 0, 1, 1, 0, 0, 0));
    Pause = 1'b0;
    repeat (2) drive(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
